// File: rtl/vcxo_dac_spi_tx.sv
// SPI transmitter for the VCXO tuning DAC: serialises {g_prefix, value} as 24-bit frames,
// with a one-entry newest-wins pending register so the loop filter never stalls.
module vcxo_dac_spi_tx #(
  parameter int unsigned g_clk_div = 4,
  parameter logic [7:0]  g_prefix  = 8'h00
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_i,
  input  logic [15:0] value_i,
  input  logic        load_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        dropped_o,
  output logic        dac_cs_n_o,
  output logic        dac_sclk_o,
  output logic        dac_sdata_o
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam logic [7:0] DIV_M1 = 8'(g_clk_div - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] shreg_q, shreg_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dropped_q, dropped_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        sdata_q, sdata_d;

  logic        cnt_zero;
  logic        gap_end;
  logic        take_next;
  logic        start;
  logic [23:0] start_frame;

  assign cnt_zero    = (cnt_q == 8'd0);
  assign gap_end     = (state_q == S_GAP) && cnt_zero;
  // A load in the final gap cycle counts as pending and wins over an older pending word.
  assign take_next   = pend_q | load_i;
  assign start       = ((state_q == S_IDLE) && load_i) || (gap_end && take_next);
  assign start_frame = {g_prefix, (load_i ? value_i : pend_val_q)};

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      phase_q    <= 1'b1;
      bit_q      <= 5'd0;
      shreg_q    <= 24'd0;
      pend_q     <= 1'b0;
      pend_val_q <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      sdata_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dropped_q  <= dropped_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_i) state_d = S_SHIFT;
      S_SHIFT: if (cnt_zero && !phase_q && (bit_q == 5'd0)) state_d = S_GAP;
      S_GAP:   if (cnt_zero) state_d = take_next ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dropped_d  = 1'b0;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    sdata_d    = sdata_q;

    if (load_i && (state_q != S_IDLE)) begin
      pend_d     = 1'b1;
      pend_val_d = value_i;
      dropped_d  = pend_q;
    end

    case (state_q)
      S_SHIFT: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (phase_q) begin
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          cnt_d   = DIV_M1;
        end else if (bit_q == 5'd0) begin
          cs_n_d  = 1'b1;
          sclk_d  = 1'b1;
          sdata_d = 1'b0;
          done_d  = 1'b1;
          cnt_d   = DIV_M1;
        end else begin
          bit_d   = bit_q - 5'd1;
          shreg_d = {shreg_q[22:0], 1'b0};
          sdata_d = shreg_q[22];
          sclk_d  = 1'b1;
          phase_d = 1'b1;
          cnt_d   = DIV_M1;
        end
      end
      S_GAP: begin
        if (!cnt_zero) cnt_d = cnt_q - 8'd1;
        else if (!take_next) busy_d = 1'b0;
      end
      default: ;
    endcase

    if (start) begin
      shreg_d = start_frame;
      sdata_d = start_frame[23];
      cs_n_d  = 1'b0;
      sclk_d  = 1'b1;
      busy_d  = 1'b1;
      phase_d = 1'b1;
      bit_d   = 5'd23;
      cnt_d   = DIV_M1;
      if (gap_end) pend_d = 1'b0;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dropped_o   = dropped_q;
  assign dac_cs_n_o  = cs_n_q;
  assign dac_sclk_o  = sclk_q;
  assign dac_sdata_o = sdata_q;

endmodule
